// File: rtl/diff_clk_monitor_pkg.sv
// -----------------------------------------------------------------------------
// diff_clk_monitor_pkg
//
// Shared definitions for the differential clock monitor:
//   - state_e            : measurement FSM states (IDLE, MEASURE, UPDATE)
//   - DEF_*              : default parameter values used by the monitor and
//                          its leg synchroniser
//   - win_cnt_width()    : width of the window counter for a given WINDOW
//
// Optional feature macro (consumed by diff_clk_monitor.sv):
//   DIFF_CLK_MONITOR_PAIR_CHECK_EN
// -----------------------------------------------------------------------------
package diff_clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        UPDATE  = 2'd2
    } state_e;

    localparam int DEF_WINDOW      = 1024;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MIN_EDGES   = 4;
    localparam int DEF_MAX_EDGES   = 512;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FAULT_LIMIT = 3;

    // Window counter runs 0..WINDOW-1, so $clog2(WINDOW) bits are enough.
    // A floor of one bit keeps degenerate values from producing a zero-width
    // vector.
    function automatic int win_cnt_width(input int window);
        return (window > 1) ? $clog2(window) : 1;
    endfunction

endpackage : diff_clk_monitor_pkg

// File: rtl/diff_clk_sync.sv
// -----------------------------------------------------------------------------
// diff_clk_sync
//
// Multi-flop synchroniser for one leg of the differential clock. The reset
// value is a parameter so the true leg can come out of reset at 0 and the
// complement leg at 1, keeping the pair complementary from the first cycle.
//
// Parameters:
//   SYNC_STAGES : number of flops in the chain (>= 2)
//   RESET_VAL   : value loaded into every flop on reset
//
// Ports:
//   CLK : system clock
//   RST : asynchronous reset, active-high
//   D   : asynchronous input leg
//   Q   : synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module diff_clk_sync
    import diff_clk_monitor_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value its predecessor held before this edge;
    // blocking assignments would collapse the chain into a single flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D};
        end
    end

    assign Q = sync_q[SYNC_STAGES-1];

endmodule : diff_clk_sync

// File: rtl/diff_clk_monitor.sv
// -----------------------------------------------------------------------------
// diff_clk_monitor
//
// Monitors the true (O) and complement (OB) legs of a differential input
// clock buffer. Both legs are synchronised into the CLK domain; rising edges
// of the true leg are counted over a fixed window of WINDOW cycles and the
// result is published with an in-range ACTIVE flag. An optional pair check
// raises a sticky FAULT when the synchronised legs stay equal for
// FAULT_LIMIT consecutive cycles.
//
// Optional feature macro:
//   DIFF_CLK_MONITOR_PAIR_CHECK_EN - when defined, the OB synchroniser, pair
//   counter and FAULT logic are built. When undefined, FAULT is tied to 0 and
//   OB / FAULT_CLR are ignored.
//
// Parameters:
//   WINDOW      : CLK cycles per measurement window (>= 4)
//   CNT_W       : width of EDGE_CNT; edge counter saturates at 2^CNT_W-1
//   MIN_EDGES   : lowest in-range edge count, inclusive
//   MAX_EDGES   : highest in-range edge count, inclusive
//   SYNC_STAGES : synchroniser depth per leg (>= 2)
//   FAULT_LIMIT : consecutive equal-leg cycles that set FAULT (>= 2)
//
// Ports:
//   CLK       : system clock, all state on its rising edge
//   RST       : asynchronous reset, active-high
//   O         : true leg, asynchronous to CLK
//   OB        : complement leg, asynchronous to CLK
//   EN        : measurement enable
//   FAULT_CLR : single-cycle clear for FAULT
//   EDGE_CNT  : edge count of the last completed window
//   CNT_VALID : one-cycle pulse when EDGE_CNT updates
//   ACTIVE    : last window count was within [MIN_EDGES, MAX_EDGES]
//   FAULT     : sticky leg-inconsistency flag
// -----------------------------------------------------------------------------
module diff_clk_monitor
    import diff_clk_monitor_pkg::*;
#(
    parameter int WINDOW      = DEF_WINDOW,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MIN_EDGES   = DEF_MIN_EDGES,
    parameter int MAX_EDGES   = DEF_MAX_EDGES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FAULT_LIMIT = DEF_FAULT_LIMIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             O,
    input  logic             OB,
    input  logic             EN,
    input  logic             FAULT_CLR,
    output logic [CNT_W-1:0] EDGE_CNT,
    output logic             CNT_VALID,
    output logic             ACTIVE,
    output logic             FAULT
);

    localparam int               WIN_W    = win_cnt_width(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(MAX_EDGES);

    // -------------------------------------------------------------------------
    // True-leg synchroniser and rising-edge detect
    // -------------------------------------------------------------------------
    logic o_sync;
    logic o_prev_q;
    logic rise;

    diff_clk_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_o (
        .CLK (CLK),
        .RST (RST),
        .D   (O),
        .Q   (o_sync)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_prev_q <= 1'b0;
        end else begin
            o_prev_q <= o_sync;
        end
    end

    assign rise = o_sync & ~o_prev_q;

    // -------------------------------------------------------------------------
    // Measurement FSM with registered outputs
    // -------------------------------------------------------------------------
    state_e           state_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] edge_q;
    logic [CNT_W-1:0] edge_d;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             cnt_valid_q;
    logic             active_q;

    // Saturating increment of the running edge count.
    // NOTE: the default assignment at the top of a combinational block keeps
    // every path driven, so no latch is inferred.
    always_comb begin
        edge_d = edge_q;
        if (rise && (edge_q != CNT_MAX)) begin
            edge_d = edge_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            win_q       <= '0;
            edge_q      <= '0;
            edge_cnt_q  <= '0;
            cnt_valid_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            cnt_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    win_q  <= '0;
                    edge_q <= '0;
                    if (EN) begin
                        state_q <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (!EN) begin
                        // Abandon the partial window; the last result is no
                        // longer trusted, so ACTIVE drops with it.
                        state_q  <= IDLE;
                        win_q    <= '0;
                        edge_q   <= '0;
                        active_q <= 1'b0;
                    end else begin
                        edge_q <= edge_d;
                        if (win_q == WIN_LAST) begin
                            win_q   <= '0;
                            state_q <= UPDATE;
                        end else begin
                            win_q <= win_q + 1'b1;
                        end
                    end
                end

                UPDATE: begin
                    edge_cnt_q  <= edge_q;
                    cnt_valid_q <= 1'b1;
                    active_q    <= (edge_q >= CNT_MIN) && (edge_q <= CNT_HI);
                    // A rise seen during the publish cycle belongs to the
                    // next window, so it seeds the fresh count.
                    edge_q      <= CNT_W'(rise);
                    win_q       <= '0;
                    state_q     <= EN ? MEASURE : IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    win_q   <= '0;
                    edge_q  <= '0;
                end
            endcase
        end
    end

    assign EDGE_CNT  = edge_cnt_q;
    assign CNT_VALID = cnt_valid_q;
    assign ACTIVE    = active_q;

    // -------------------------------------------------------------------------
    // Optional leg-pair consistency check
    // -------------------------------------------------------------------------
`ifdef DIFF_CLK_MONITOR_PAIR_CHECK_EN
    localparam int                PAIR_W     = $clog2(FAULT_LIMIT + 1);
    localparam logic [PAIR_W-1:0] PAIR_LIMIT = PAIR_W'(FAULT_LIMIT);

    logic              ob_sync;
    logic [PAIR_W-1:0] pair_q;
    logic [PAIR_W-1:0] pair_d;
    logic              fault_q;
    logic              fault_d;

    diff_clk_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ob (
        .CLK (CLK),
        .RST (RST),
        .D   (OB),
        .Q   (ob_sync)
    );

    // One cycle of equal legs at each transition is normal skew through the
    // two independent synchronisers; only a run of FAULT_LIMIT equal cycles
    // is treated as a broken pair. The counter saturates so a stuck pair
    // keeps asserting the set condition, which overrides FAULT_CLR.
    always_comb begin
        pair_d = '0;
        if (o_sync == ob_sync) begin
            pair_d = (pair_q == PAIR_LIMIT) ? pair_q : pair_q + 1'b1;
        end

        fault_d = fault_q;
        if (pair_d == PAIR_LIMIT) begin
            fault_d = 1'b1;
        end else if (FAULT_CLR) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pair_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            fault_q <= fault_d;
        end
    end

    assign FAULT = fault_q;
`else
    // Pair check not built: the complement leg and its clear are ignored.
    logic unused_pair_inputs;
    assign unused_pair_inputs = OB ^ FAULT_CLR ^ (FAULT_LIMIT < 2);
    assign FAULT              = 1'b0;
`endif

endmodule : diff_clk_monitor

// File: tb/tb_diff_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_diff_clk_monitor
//
// Self-checking bench for diff_clk_monitor with default parameters
// (WINDOW=1024, MIN_EDGES=4, MAX_EDGES=512, FAULT_LIMIT=3). A free-running
// generator drives O/OB as a complementary square wave of a selectable period
// (0 = stopped, O low / OB high) or holds both legs high. Each table vector
// restarts a measurement from IDLE, so the window sees exactly 1024 rise
// samples and the expected count is 1024/period.
// -----------------------------------------------------------------------------
module tb_diff_clk_monitor;

    logic        CLK       = 1'b0;
    logic        RST       = 1'b1;
    logic        O         = 1'b0;
    logic        OB        = 1'b1;
    logic        EN        = 1'b0;
    logic        FAULT_CLR = 1'b0;
    logic [15:0] EDGE_CNT;
    logic        CNT_VALID;
    logic        ACTIVE;
    logic        FAULT;

    int errors = 0;
    int checks = 0;

    int cyc     = 0;
    int period  = 8;
    bit hold_eq = 1'b0;

    typedef struct {
        int    period;
        int    exp_cnt;
        bit    exp_active;
        string name;
    } vec_t;

    vec_t vecs[6];

    diff_clk_monitor #(
        .WINDOW      (1024),
        .CNT_W       (16),
        .MIN_EDGES   (4),
        .MAX_EDGES   (512),
        .SYNC_STAGES (2),
        .FAULT_LIMIT (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .O         (O),
        .OB        (OB),
        .EN        (EN),
        .FAULT_CLR (FAULT_CLR),
        .EDGE_CNT  (EDGE_CNT),
        .CNT_VALID (CNT_VALID),
        .ACTIVE    (ACTIVE),
        .FAULT     (FAULT)
    );

    always #5 CLK = ~CLK;

    // Leg generator, updated away from the sampling edge.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (hold_eq) begin
            O  = 1'b1;
            OB = 1'b1;
        end else if (period == 0) begin
            O  = 1'b0;
            OB = 1'b1;
        end else begin
            O  = (cyc % period) < (period / 2);
            OB = ~O;
        end
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Waits for CNT_VALID; lat counts the edges strictly before the pulse.
    task automatic wait_valid(input int budget, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && (lat < budget)) begin
            @(negedge CLK);
            if (CNT_VALID) seen = 1'b1;
            else           lat  = lat + 1;
        end
    endtask

    // Restart from IDLE with a new leg period and check the first window.
    task automatic run_window(input int per, input int exp_cnt,
                              input bit exp_act, input string name);
        int lat;
        bit seen;
        EN = 1'b0;
        @(negedge CLK);
        period = per;
        repeat (8) @(negedge CLK);
        EN = 1'b1;
        wait_valid(2000, lat, seen);
        check({name, " valid seen"}, 32'(seen), 1);
        if (seen) begin
            check({name, " latency"},  lat,      1025);
            check({name, " edge_cnt"}, EDGE_CNT, exp_cnt);
            check({name, " active"},   ACTIVE,   32'(exp_act));
            @(negedge CLK);
            check({name, " valid one cycle"}, CNT_VALID, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        int c2, c3;
        bit a2, a3;
        int nvalid;
        int nfault;
        bit ok;

        vecs[0] = '{8,   128, 1'b1, "nominal period 8"};
        vecs[1] = '{0,   0,   1'b0, "stopped leg"};
        vecs[2] = '{2,   512, 1'b1, "toggle every cycle"};
        vecs[3] = '{256, 4,   1'b1, "min boundary"};
        vecs[4] = '{512, 2,   1'b0, "below min"};
        vecs[5] = '{4,   256, 1'b1, "period 4"};

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset edge_cnt",  EDGE_CNT,  0);
        check("reset cnt_valid", CNT_VALID, 0);
        check("reset active",    ACTIVE,    0);
        check("reset fault",     FAULT,     0);
        RST = 1'b0;

        // Table-driven windows
        for (int i = 0; i < 6; i++) begin
            run_window(vecs[i].period, vecs[i].exp_cnt, vecs[i].exp_active,
                       vecs[i].name);
        end

        // Free-running toggle: later windows span 1025 samples, so two
        // consecutive windows report 512 and 513 in some order.
        run_window(2, 512, 1'b1, "toggle first window");
        wait_valid(2000, lat, seen);
        check("toggle window2 seen", 32'(seen), 1);
        c2 = EDGE_CNT;
        a2 = ACTIVE;
        wait_valid(2000, lat, seen);
        check("toggle window3 seen", 32'(seen), 1);
        check("window period", lat, 1024);
        c3 = EDGE_CNT;
        a3 = ACTIVE;
        ok = ((c2 == 512) && a2 && (c3 == 513) && !a3) ||
             ((c2 == 513) && !a2 && (c3 == 512) && a3);
        check("max boundary 512 active / 513 inactive", 32'(ok), 1);

        // Leg fault
        period = 8;
        repeat (10) @(negedge CLK);
`ifdef DIFF_CLK_MONITOR_PAIR_CHECK_EN
        @(posedge CLK);
        #1 hold_eq = 1'b1;
        @(negedge CLK);
        repeat (2) @(negedge CLK);
        check("fault not before limit", FAULT, 0);
        repeat (3) @(negedge CLK);
        check("fault set after limit", FAULT, 1);
        FAULT_CLR = 1'b1;
        @(negedge CLK);
        FAULT_CLR = 1'b0;
        check("fault clr while equal", FAULT, 1);
        @(posedge CLK);
        #1 hold_eq = 1'b0;
        repeat (6) @(negedge CLK);
        check("fault sticky after restore", FAULT, 1);
        FAULT_CLR = 1'b1;
        @(negedge CLK);
        FAULT_CLR = 1'b0;
        check("fault cleared", FAULT, 0);
`else
        @(posedge CLK);
        #1 hold_eq = 1'b1;
        nfault = 0;
        repeat (10) begin
            @(negedge CLK);
            if (FAULT !== 1'b0) nfault = nfault + 1;
        end
        check("fault stays 0 without pair check", nfault, 0);
        @(posedge CLK);
        #1 hold_eq = 1'b0;
`endif
        run_window(8, 128, 1'b1, "count after equal legs");

        // Reset mid-window
        repeat (100) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("rst mid edge_cnt",  EDGE_CNT,  0);
        check("rst mid active",    ACTIVE,    0);
        check("rst mid cnt_valid", CNT_VALID, 0);
        check("rst mid fault",     FAULT,     0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("fault after rst release",  FAULT,  0);
        check("active after rst release", ACTIVE, 0);

        // EN drop mid-window
        run_window(8, 128, 1'b1, "before en drop");
        repeat (498) @(negedge CLK);
        EN = 1'b0;
        repeat (2) @(negedge CLK);
        check("en drop active", ACTIVE, 0);
        nvalid = 0;
        repeat (1100) begin
            @(negedge CLK);
            if (CNT_VALID) nvalid = nvalid + 1;
        end
        check("en drop no cnt_valid", nvalid, 0);
        check("en drop edge_cnt held", EDGE_CNT, 128);
        run_window(8, 128, 1'b1, "re-enable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_diff_clk_monitor
